text_scanner: RTL and testbench
===============================

TEXT_SCANNER -- requirements
Module: text_scanner

Interface
REQ-001 Parameter COLUMNS, default 16, text columns per row; power of two.
REQ-002 Parameter ROWS, default 4, text rows; power of two.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  frame request pulse; sampled only in IDLE.
REQ-006 busy  output  1  high from the cycle after accepted start until done.
REQ-007 done  output  1  one-cycle pulse after the last pixel handshake.
REQ-008 write_enable  input  1  text RAM write strobe.
REQ-009 write_address  input  log2(COLUMNS*ROWS) (6)  index row*COLUMNS+column.
REQ-010 write_character  input  7  character code to store.
REQ-011 pixel_valid  output  1  pixel_dot/x/y/last valid.
REQ-012 pixel_ready  input  1  consumer accepts the pixel when high with pixel_valid.
REQ-013 pixel_dot  output  1  glyph dot value.
REQ-014 pixel_x  output  log2(COLUMNS*8) (7)  screen pixel column.
REQ-015 pixel_y  output  log2(ROWS*8) (5)  screen pixel row.
REQ-016 pixel_last  output  1  high on the final pixel of a frame.

Function
REQ-017 Text RAM: COLUMNS*ROWS x 7-bit register array, asynchronous read, write on clock edge when write_enable high, in any state.
REQ-018 Same-cycle write and scan read of one address: the scan gets the old value.
REQ-019 States IDLE, SCAN, DRAIN; IDLE->SCAN on start; SCAN->DRAIN after the last ROM read issues; DRAIN->IDLE when the output buffer and in-flight slot are empty, asserting done that same cycle.
REQ-020 start while busy is ignored; start in the done cycle is ignored.
REQ-021 Scan order: raster; pixel_y outer 0..ROWS*8-1, pixel_x inner 0..COLUMNS*8-1.
REQ-022 Per issued read: ROM x = pixel_x[2:0], y = pixel_y[2:0], character = RAM[(pixel_y>>3)*COLUMNS + (pixel_x>>3)].
REQ-023 character_rom dot is registered: valid exactly one cycle after issue; captured unconditionally into the output buffer.
REQ-024 Output buffer: 2-entry FIFO of {dot, x, y, last}; head drives pixel_* outputs.
REQ-025 Issue rule: a read issues in SCAN iff (occupancy + in_flight - pop) < 2, pop = pixel_valid & pixel_ready.
REQ-026 With pixel_ready held high, throughput is one pixel per cycle; first pixel_valid 2 cycles after start is sampled.
REQ-027 Holding pixel_ready low keeps pixel_* stable and stalls scan coordinates; no pixel lost or duplicated.
REQ-028 Coordinates wrap: x from COLUMNS*8-1 to 0 increments y; the final coordinate sets last and ends SCAN.
REQ-029 Frame = COLUMNS*ROWS*64 pixels (4096 default); exactly one pixel_last per frame.

Reset
REQ-030 Reset: state IDLE, busy 0, done 0, pixel_valid 0, buffer and in-flight cleared, coordinates 0.
REQ-031 Reset mid-frame abandons the frame without done; text RAM contents are retained (not reset).
REQ-032 Outputs pixel_dot/x/y/last read 0 while pixel_valid is 0 after reset.

Structure
REQ-033 Shared package holds GLYPH_SIZE=8, CHARACTER_WIDTH=7, and state encodings IDLE/SCAN/DRAIN.
REQ-034 Sub-module: the existing character_rom, instantiated once, driven by clock.
REQ-035 The output FIFO is inline logic, not a separate module.

Verification
REQ-036 Write 65 to all RAM, start, ready high -> 4096 pixels, raster order, dots match glyph 65 tiled, done 1 cycle after last handshake.
REQ-037 Distinct codes per cell (address+32) -> pixel (x,y) dot equals ROM glyph of RAM[(y>>3)*16+(x>>3)] at (x&7,y&7).
REQ-038 pixel_ready random 50% -> same 4096-pixel sequence as REQ-036, outputs stable during stalls, one pixel_last.
REQ-039 start pulsed during SCAN and in the done cycle -> ignored; exactly one frame produced.
REQ-040 reset asserted at pixel 1000 -> next cycle pixel_valid 0, busy 0, no done; new start yields full frame from (0,0) with retained RAM.
REQ-041 Write cell 0 during the scan of pixel (0,0) issue -> old code used that read; new code used from pixel (1,0).

Source files
------------

// File: rtl/text_scanner_pkg.sv
// Shared constants, scan state encoding and the glyph pattern used by
// the text scanner and its character ROM.
package text_scanner_pkg;

   localparam int unsigned GLYPH_SIZE      = 8;
   localparam int unsigned CHARACTER_WIDTH = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2
   } scan_state_t;

   // Synthetic font: one 8-dot row per (character, glyph row), MSB is the leftmost dot.
   function automatic logic [GLYPH_SIZE-1:0] glyph_row(
      input logic [CHARACTER_WIDTH-1:0] character,
      input logic [2:0]                 row
   );
      glyph_row = 8'({1'b0, character} * 8'd5 + {5'd0, row} * 8'd29);
   endfunction

endpackage

// File: rtl/text_scanner_character_rom.sv
// Character generator ROM: one dot per (character, x, y), registered,
// so the dot is valid the cycle after the address is presented.
module character_rom
   import text_scanner_pkg::*;
(
   input  logic                       clock,
   input  logic [2:0]                 x,
   input  logic [2:0]                 y,
   input  logic [CHARACTER_WIDTH-1:0] character,
   output logic                       dot
);

   logic [GLYPH_SIZE-1:0] row_bits;

   always_comb row_bits = glyph_row(character, y);

   // ~x selects from the MSB, so x = 0 is the leftmost dot.
   always_ff @(posedge clock) dot <= row_bits[~x];

endmodule

// File: rtl/text_scanner.sv
// Text-mode frame scanner: walks the screen in raster order, looks up each
// cell's character in the text RAM and streams glyph dots out via ready/valid.
module text_scanner
   import text_scanner_pkg::*;
#(
   parameter  int unsigned COLUMNS = 16,
   parameter  int unsigned ROWS    = 4,
   localparam int unsigned AW      = $clog2(COLUMNS * ROWS),
   localparam int unsigned XW      = $clog2(COLUMNS * GLYPH_SIZE),
   localparam int unsigned YW      = $clog2(ROWS * GLYPH_SIZE)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   input  logic                       write_enable,
   input  logic [AW-1:0]              write_address,
   input  logic [CHARACTER_WIDTH-1:0] write_character,
   output logic                       pixel_valid,
   input  logic                       pixel_ready,
   output logic                       pixel_dot,
   output logic [XW-1:0]              pixel_x,
   output logic [YW-1:0]              pixel_y,
   output logic                       pixel_last
);

   scan_state_t state, state_next;

   logic [CHARACTER_WIDTH-1:0] ram [COLUMNS*ROWS];
   logic [AW-1:0]              scan_addr;
   logic [XW-1:0]              cx;
   logic [YW-1:0]              cy;
   logic                       rom_dot;

   logic                       in_flight;
   logic [XW-1:0]              fl_x;
   logic [YW-1:0]              fl_y;
   logic                       fl_last;

   logic                       buf_dot  [2];
   logic [XW-1:0]              buf_x    [2];
   logic [YW-1:0]              buf_y    [2];
   logic                       buf_last [2];
   logic                       wr_ptr, rd_ptr;
   logic [1:0]                 count;

   logic                       pop, issue, last_coord;
   logic [2:0]                 pending;

   always_ff @(posedge clock) begin
      if (write_enable) ram[write_address] <= write_character;
   end

   always_comb begin
      scan_addr  = {cy[YW-1:3], cx[XW-1:3]};
      last_coord = (&cx) && (&cy);
      pop        = pixel_valid && pixel_ready;
      // Slots already committed after this cycle's pop; the ROM output is always captured.
      pending    = 3'(count) + 3'(in_flight) - 3'(pop);
      issue      = (state == SCAN) && (pending < 3'd2);
   end

   character_rom u_rom (
      .clock     (clock),
      .x         (cx[2:0]),
      .y         (cy[2:0]),
      .character (ram[scan_addr]),
      .dot       (rom_dot)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         cx        <= '0;
         cy        <= '0;
         in_flight <= 1'b0;
         fl_x      <= '0;
         fl_y      <= '0;
         fl_last   <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= '0;
      end else begin
         state     <= state_next;
         in_flight <= issue;
         if (issue) begin
            fl_x    <= cx;
            fl_y    <= cy;
            fl_last <= last_coord;
            cx      <= cx + 1'b1;
            if (&cx) cy <= cy + 1'b1;
         end
         if (in_flight) wr_ptr <= ~wr_ptr;
         if (pop)       rd_ptr <= ~rd_ptr;
         count <= count + 2'(in_flight) - 2'(pop);
      end
   end

   always_ff @(posedge clock) begin
      if (in_flight) begin
         buf_dot[wr_ptr]  <= rom_dot;
         buf_x[wr_ptr]    <= fl_x;
         buf_y[wr_ptr]    <= fl_y;
         buf_last[wr_ptr] <= fl_last;
      end
   end

   always_comb begin
      state_next = state;
      done       = 1'b0;
      busy       = (state != IDLE);
      unique case (state)
         IDLE:  if (start) state_next = SCAN;
         SCAN:  if (issue && last_coord) state_next = DRAIN;
         DRAIN: begin
            if ((count == 2'd0) && !in_flight) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      pixel_valid = (count != 2'd0);
      pixel_dot   = pixel_valid && buf_dot[rd_ptr];
      pixel_x     = pixel_valid ? buf_x[rd_ptr] : '0;
      pixel_y     = pixel_valid ? buf_y[rd_ptr] : '0;
      pixel_last  = pixel_valid && buf_last[rd_ptr];
   end

endmodule

// File: tb/tb_text_scanner.sv
// Self-checking bench for text_scanner: a frame-level model predicts every
// pixel in raster order; a per-cycle monitor checks handshakes, stalls and done.
module tb_text_scanner;

   localparam int NPIX = 4096;

   logic       clock = 1'b0;
   logic       reset, start, write_enable, pixel_ready;
   logic [5:0] write_address;
   logic [6:0] write_character;
   logic       busy, done, pixel_valid, pixel_dot, pixel_last;
   logic [6:0] pixel_x;
   logic [4:0] pixel_y;

   typedef struct packed {
      logic       dot;
      logic [6:0] x;
      logic [4:0] y;
      logic       last;
   } pix_t;

   pix_t exp_q[$];
   int   model_ram [64];
   int   checks = 0;
   int   failures = 0;
   bit   frame_dots [NPIX];
   int   frame_pix = 0;
   int   last_cnt = 0;
   bit   done_due = 1'b0;
   bit   prev_stall = 1'b0;
   pix_t prev_out;
   int   ready_mode = 0;

   always #5 clock = ~clock;

   text_scanner #(.COLUMNS(16), .ROWS(4)) dut (
      .clock           (clock),
      .reset           (reset),
      .start           (start),
      .busy            (busy),
      .done            (done),
      .write_enable    (write_enable),
      .write_address   (write_address),
      .write_character (write_character),
      .pixel_valid     (pixel_valid),
      .pixel_ready     (pixel_ready),
      .pixel_dot       (pixel_dot),
      .pixel_x         (pixel_x),
      .pixel_y         (pixel_y),
      .pixel_last      (pixel_last)
   );

   // Glyph row value is (code*5 + row*29) mod 256, leftmost dot = bit 7.
   function automatic bit glyph_dot(int code, int gx, int gy);
      int r;
      r = (code * 5 + gy * 29) % 256;
      return bit'((r >> (7 - gx)) & 1);
   endfunction

   task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic fail_now(string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic write_cell(int a, int c);
      write_enable    = 1'b1;
      write_address   = 6'(a);
      write_character = 7'(c);
      tick();
      write_enable = 1'b0;
      model_ram[a] = c;
   endtask

   task automatic build_expected();
      pix_t p;
      exp_q.delete();
      frame_pix = 0;
      last_cnt  = 0;
      for (int y = 0; y < 32; y++) begin
         for (int x = 0; x < 128; x++) begin
            p.x    = 7'(x);
            p.y    = 5'(y);
            p.dot  = glyph_dot(model_ram[(y / 8) * 16 + x / 8], x % 8, y % 8);
            p.last = (x == 127) && (y == 31);
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic launch();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(bit glitch);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         @(negedge clock);
         start = glitch && (c == 100);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      start = 1'b0;
      if (!seen) fail_now("done_timeout");
      if (seen && glitch) begin
         start = 1'b1;
         @(negedge clock);
         start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            check("post_done_start_busy", busy, 0);
            check("post_done_start_valid", pixel_valid, 0);
            @(negedge clock);
         end
      end
      check("frame_pixels", frame_pix, NPIX);
      check("last_count", last_cnt, 1);
      check("queue_empty", exp_q.size(), 0);
      @(negedge clock);
      check("idle_after_done", busy, 0);
   endtask

   initial begin
      pixel_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         pixel_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clock) begin
      pix_t e;
      if (reset) begin
         prev_stall = 1'b0;
         done_due   = 1'b0;
      end else begin
         check("done", done, done_due);
         done_due = 1'b0;
         if (prev_stall) begin
            check("stall_valid", pixel_valid, 1);
            check("stall_hold", {pixel_dot, pixel_x, pixel_y, pixel_last}, prev_out);
         end
         if (pixel_valid && pixel_ready) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_pixel");
            end else begin
               e = exp_q.pop_front();
               check("pix_x", pixel_x, e.x);
               check("pix_y", pixel_y, e.y);
               check("pix_dot", pixel_dot, e.dot);
               check("pix_last", pixel_last, e.last);
               if (e.last) done_due = 1'b1;
            end
            if (frame_pix < NPIX) frame_dots[frame_pix] = pixel_dot;
            frame_pix++;
            if (pixel_last) last_cnt++;
         end
         prev_stall = pixel_valid && !pixel_ready;
         prev_out   = {pixel_dot, pixel_x, pixel_y, pixel_last};
      end
   end

   initial begin
      int old_code;
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      write_enable = 1'b0;
      write_address = '0;
      write_character = '0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clock);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", pixel_valid, 0);
      check("rst_dot", pixel_dot, 0);
      check("rst_x", pixel_x, 0);
      check("rst_y", pixel_y, 0);
      check("rst_last", pixel_last, 0);
      tick();

      // Uniform text, ready high, start-to-valid latency.
      for (int a = 0; a < 64; a++) write_cell(a, 65);
      build_expected();
      launch();
      @(negedge clock);
      check("lat_busy", busy, 1);
      check("lat_valid_c0", pixel_valid, 0);
      @(negedge clock);
      check("lat_valid_c1", pixel_valid, 0);
      @(negedge clock);
      check("lat_valid_c2", pixel_valid, 1);
      wait_done(1'b0);
      check("pin65_p0", frame_dots[0], 0);
      check("pin65_p1", frame_dots[1], 1);
      check("pin65_p128", frame_dots[128], 0);
      check("pin65_p130", frame_dots[130], 1);

      // Distinct code per cell.
      for (int a = 0; a < 64; a++) write_cell(a, a + 32);
      build_expected();
      launch();
      wait_done(1'b0);
      check("pin_distinct_p0", frame_dots[0], 1);
      check("pin_distinct_p1", frame_dots[1], 0);
      check("pin_distinct_p8", frame_dots[8], 1);
      check("pin_distinct_p138", frame_dots[138], 0);

      // Random backpressure on uniform text.
      for (int a = 0; a < 64; a++) write_cell(a, 65);
      ready_mode = 1;
      build_expected();
      launch();
      wait_done(1'b0);
      ready_mode = 0;
      tick();

      // Start pulses during SCAN and in the done cycle must be ignored.
      for (int a = 0; a < 64; a++) write_cell(a, a + 32);
      build_expected();
      launch();
      wait_done(1'b1);

      // Reset after 1000 pixels, then a clean frame from retained RAM.
      build_expected();
      launch();
      hit = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clock);
         if (frame_pix >= 1000) begin
            hit = 1'b1;
            break;
         end
      end
      if (!hit) fail_now("pixel1000_timeout");
      #1 reset = 1'b1;
      @(negedge clock);
      check("midreset_valid", pixel_valid, 0);
      check("midreset_busy", busy, 0);
      check("midreset_done", done, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      exp_q.delete();
      tick();
      build_expected();
      launch();
      wait_done(1'b0);

      // Overwrite cell 0 in the cycle (0,0) is issued.
      old_code = model_ram[0];
      model_ram[0] = 65;
      build_expected();
      exp_q[0].dot = glyph_dot(old_code, 0, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      write_enable    = 1'b1;
      write_address   = 6'd0;
      write_character = 7'd65;
      tick();
      write_enable = 1'b0;
      wait_done(1'b0);
      check("wr_race_p0_old", frame_dots[0], 1);
      check("wr_race_p1_new", frame_dots[1], 1);
      check("wr_race_p2_new", frame_dots[2], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
